wb_unified_mem: RTL and testbench



---
 rtl/wb_unified_mem.sv | 186 ++++++++++++++++++
 tb/tb_wb_unified_mem.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_unified_mem.sv
// wb_unified_mem: dual-port Wishbone memory; instruction (read-only) and data (byte-masked RW) ports share one word array.
// Define WB_MEM_TOHOST_EN to enable tohost pass/fail monitoring on the data port.
module wb_unified_mem #(
  parameter int unsigned DEPTH_WORDS = 8192,
  parameter int unsigned IWAIT       = 0,
  parameter int unsigned DWAIT       = 0,
  parameter int unsigned TOHOST_WORD = 1024,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] iwb_adr_i,
  input  logic        iwb_cyc_i,
  input  logic        iwb_stb_i,
  output logic [31:0] iwb_dat_o,
  output logic        iwb_ack_o,
  output logic        iwb_err_o,
  input  logic [31:0] dwb_adr_i,
  input  logic [31:0] dwb_dat_i,
  input  logic        dwb_we_i,
  input  logic [3:0]  dwb_sel_i,
  input  logic        dwb_cyc_i,
  input  logic        dwb_stb_i,
  output logic [31:0] dwb_dat_o,
  output logic        dwb_ack_o,
  output logic        dwb_err_o,
  output logic        tohost_valid,
  output logic        tohost_pass,
  output logic [30:0] tohost_code
);
  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  logic [31:0] mem [DEPTH_WORDS];

  initial begin
    for (int unsigned w = 0; w < DEPTH_WORDS; w++) mem[w] = 32'h00000013;
  end

  logic          i_req, i_in, i_go;
  logic [AW-1:0] i_a;
  state_t        i_st, i_nxt;
  logic [3:0]    i_cnt, i_cnt_nxt;

  logic          d_req, d_in, d_go, d_wr;
  logic [AW-1:0] d_a;
  logic [31:0]   d_merged;
  state_t        d_st, d_nxt;
  logic [3:0]    d_cnt, d_cnt_nxt;

  logic unused_adr_lsbs;
  assign unused_adr_lsbs = ^{iwb_adr_i[1:0], dwb_adr_i[1:0]};

  assign i_req = iwb_cyc_i && iwb_stb_i;
  assign i_in  = {2'b00, iwb_adr_i[31:2]} < DEPTH_WORDS;
  assign i_a   = iwb_adr_i[AW+1:2];
  assign d_req = dwb_cyc_i && dwb_stb_i;
  assign d_in  = {2'b00, dwb_adr_i[31:2]} < DEPTH_WORDS;
  assign d_a   = dwb_adr_i[AW+1:2];

  // The counter is loaded with the wait count and RESP is entered on the edge
  // where it would reach 0, giving exactly wait+1 cycles of latency.
  always_comb begin
    i_nxt     = i_st;
    i_cnt_nxt = i_cnt;
    i_go      = 1'b0;
    case (i_st)
      S_IDLE: if (i_req) begin
        if (IWAIT == 0) begin
          i_go  = 1'b1;
          i_nxt = S_RESP;
        end else begin
          i_nxt     = S_WAIT;
          i_cnt_nxt = 4'(IWAIT);
        end
      end
      S_WAIT: begin
        if (!i_req) begin
          i_nxt = S_IDLE;
        end else if (i_cnt == 4'd1) begin
          i_go      = 1'b1;
          i_nxt     = S_RESP;
          i_cnt_nxt = '0;
        end else begin
          i_cnt_nxt = i_cnt - 4'd1;
        end
      end
      default: i_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    d_nxt     = d_st;
    d_cnt_nxt = d_cnt;
    d_go      = 1'b0;
    case (d_st)
      S_IDLE: if (d_req) begin
        if (DWAIT == 0) begin
          d_go  = 1'b1;
          d_nxt = S_RESP;
        end else begin
          d_nxt     = S_WAIT;
          d_cnt_nxt = 4'(DWAIT);
        end
      end
      S_WAIT: begin
        if (!d_req) begin
          d_nxt = S_IDLE;
        end else if (d_cnt == 4'd1) begin
          d_go      = 1'b1;
          d_nxt     = S_RESP;
          d_cnt_nxt = '0;
        end else begin
          d_cnt_nxt = d_cnt - 4'd1;
        end
      end
      default: d_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_st  <= S_IDLE;
      i_cnt <= '0;
      d_st  <= S_IDLE;
      d_cnt <= '0;
    end else begin
      i_st  <= i_nxt;
      i_cnt <= i_cnt_nxt;
      d_st  <= d_nxt;
      d_cnt <= d_cnt_nxt;
    end
  end

  always_comb begin
    d_merged = mem[d_a];
    for (int unsigned b = 0; b < 4; b++) begin
      if (dwb_sel_i[b]) d_merged[8*b +: 8] = dwb_dat_i[8*b +: 8];
    end
  end

  // The array has no reset, so the write strobe must be masked while rst is high.
  assign d_wr = d_go && !rst && d_in && dwb_we_i;

  always_ff @(posedge clk) begin
    if (d_wr) mem[d_a] <= d_merged;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iwb_ack_o <= 1'b0;
      iwb_err_o <= 1'b0;
      iwb_dat_o <= '0;
      dwb_ack_o <= 1'b0;
      dwb_err_o <= 1'b0;
      dwb_dat_o <= '0;
    end else begin
      iwb_ack_o <= i_go && i_in;
      iwb_err_o <= i_go && !i_in;
      iwb_dat_o <= (i_go && i_in) ? mem[i_a] : '0;
      dwb_ack_o <= d_go && d_in;
      dwb_err_o <= d_go && !d_in;
      dwb_dat_o <= (d_go && d_in) ? mem[d_a] : '0;
    end
  end

`ifdef WB_MEM_TOHOST_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tohost_valid <= 1'b0;
      tohost_pass  <= 1'b0;
      tohost_code  <= '0;
    end else if (d_wr && !tohost_valid && d_a == AW'(TOHOST_WORD) && d_merged != '0) begin
      tohost_valid <= 1'b1;
      tohost_pass  <= d_merged == 32'd1;
      tohost_code  <= d_merged[31:1];
    end
  end
`else
  assign tohost_valid = 1'b0;
  assign tohost_pass  = 1'b0;
  assign tohost_code  = '0;
`endif

endmodule

// File: tb/tb_wb_unified_mem.sv
// Randomized self-checking bench for wb_unified_mem against an associative-array memory model.
`timescale 1ns/1ps
module tb_wb_unified_mem;
    localparam int unsigned DEPTH = 8192;
    localparam int unsigned IW    = 0;
    localparam int unsigned DW    = 3;
    localparam int unsigned TH    = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] iwb_adr_i, iwb_dat_o, dwb_adr_i, dwb_dat_i, dwb_dat_o;
    logic        iwb_cyc_i, iwb_stb_i, iwb_ack_o, iwb_err_o;
    logic        dwb_we_i, dwb_cyc_i, dwb_stb_i, dwb_ack_o, dwb_err_o;
    logic [3:0]  dwb_sel_i;
    logic        tohost_valid, tohost_pass;
    logic [30:0] tohost_code;

    wb_unified_mem #(
        .DEPTH_WORDS(DEPTH), .IWAIT(IW), .DWAIT(DW), .TOHOST_WORD(TH), .INIT_FILE("")
    ) dut (
        .clk(clk), .rst(rst),
        .iwb_adr_i(iwb_adr_i), .iwb_cyc_i(iwb_cyc_i), .iwb_stb_i(iwb_stb_i),
        .iwb_dat_o(iwb_dat_o), .iwb_ack_o(iwb_ack_o), .iwb_err_o(iwb_err_o),
        .dwb_adr_i(dwb_adr_i), .dwb_dat_i(dwb_dat_i), .dwb_we_i(dwb_we_i), .dwb_sel_i(dwb_sel_i),
        .dwb_cyc_i(dwb_cyc_i), .dwb_stb_i(dwb_stb_i),
        .dwb_dat_o(dwb_dat_o), .dwb_ack_o(dwb_ack_o), .dwb_err_o(dwb_err_o),
        .tohost_valid(tohost_valid), .tohost_pass(tohost_pass), .tohost_code(tohost_code)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: sparse word store, NOP background, first nonzero tohost write latched.
    logic [31:0] ref_mem [int unsigned];
    logic        ref_th_valid = 1'b0;
    logic [31:0] ref_th_word  = '0;

    function automatic logic [31:0] ref_rd(input int unsigned idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : 32'h00000013;
    endfunction

    task automatic ref_wr(input int unsigned idx, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] w;
        if (idx >= DEPTH) return;
        w = ref_rd(idx);
        for (int b = 0; b < 4; b++) if (sel[b]) w[8*b +: 8] = d[8*b +: 8];
        ref_mem[idx] = w;
`ifdef WB_MEM_TOHOST_EN
        if (idx == TH && w != 0 && !ref_th_valid) begin
            ref_th_valid = 1'b1;
            ref_th_word  = w;
        end
`endif
    endtask

    task automatic check_tohost(input string tag);
        check({tag, "_th_valid"}, 32'(tohost_valid), 32'(ref_th_valid));
        check({tag, "_th_pass"}, 32'(tohost_pass), 32'(ref_th_valid && ref_th_word == 32'd1));
        check({tag, "_th_code"}, 32'(tohost_code), ref_th_valid ? (ref_th_word >> 1) : 32'd0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_flags"}, 32'({iwb_ack_o, iwb_err_o, dwb_ack_o, dwb_err_o}), 32'd0);
        check({tag, "_idat"}, iwb_dat_o, 32'd0);
        check({tag, "_ddat"}, dwb_dat_o, 32'd0);
    endtask

    task automatic i_access(input logic [31:0] adr, output logic [31:0] rdat,
                            output logic ack, output logic err, output int lat);
        iwb_adr_i = adr; iwb_cyc_i = 1'b1; iwb_stb_i = 1'b1;
        lat = 0; ack = 1'b0; err = 1'b0; rdat = '0;
        while (lat < 40) begin
            @(posedge clk); #1; lat++;
            if (iwb_ack_o || iwb_err_o) begin
                ack = iwb_ack_o; err = iwb_err_o; rdat = iwb_dat_o;
                break;
            end
        end
        iwb_cyc_i = 1'b0; iwb_stb_i = 1'b0;
    endtask

    task automatic d_access(input logic [31:0] adr, input logic [31:0] wdat, input logic we,
                            input logic [3:0] sel, output logic [31:0] rdat,
                            output logic ack, output logic err, output int lat);
        dwb_adr_i = adr; dwb_dat_i = wdat; dwb_we_i = we; dwb_sel_i = sel;
        dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
        lat = 0; ack = 1'b0; err = 1'b0; rdat = '0;
        while (lat < 40) begin
            @(posedge clk); #1; lat++;
            if (dwb_ack_o || dwb_err_o) begin
                ack = dwb_ack_o; err = dwb_err_o; rdat = dwb_dat_o;
                break;
            end
        end
        dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0; dwb_we_i = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] adr, input string tag, output logic [31:0] rdat);
        int unsigned idx = 32'(adr[31:2]);
        logic inr = idx < DEPTH;
        logic ack, err;
        int lat;
        i_access(adr, rdat, ack, err, lat);
        check({tag, "_lat"}, 32'(lat), IW + 1);
        check({tag, "_ack"}, 32'(ack), 32'(inr));
        check({tag, "_err"}, 32'(err), 32'(!inr));
        check({tag, "_dat"}, rdat, inr ? ref_rd(idx) : 32'd0);
        @(posedge clk); #1;
        check({tag, "_1cyc"}, 32'({iwb_ack_o, iwb_err_o}), 32'd0);
    endtask

    task automatic do_data(input logic [31:0] adr, input logic [31:0] wdat, input logic we,
                           input logic [3:0] sel, input string tag, output logic [31:0] rdat);
        int unsigned idx = 32'(adr[31:2]);
        logic inr = idx < DEPTH;
        logic [31:0] exp_rd = inr ? ref_rd(idx) : 32'd0;
        logic ack, err;
        int lat;
        d_access(adr, wdat, we, sel, rdat, ack, err, lat);
        if (we) ref_wr(idx, wdat, sel);
        check({tag, "_lat"}, 32'(lat), DW + 1);
        check({tag, "_ack"}, 32'(ack), 32'(inr));
        check({tag, "_err"}, 32'(err), 32'(!inr));
        if (!we || !inr) check({tag, "_dat"}, rdat, exp_rd);
        check_tohost(tag);
        @(posedge clk); #1;
        check({tag, "_1cyc"}, 32'({dwb_ack_o, dwb_err_o}), 32'd0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1; #1;
        ref_th_valid = 1'b0;
        ref_th_word  = '0;
        check_quiet("rstp");
        check_tohost("rstp");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, rd2;
        logic ack, err, seen;
        int lat;
        rst = 1'b1;
        iwb_adr_i = '0; iwb_cyc_i = 1'b0; iwb_stb_i = 1'b0;
        dwb_adr_i = '0; dwb_dat_i = '0; dwb_we_i = 1'b0; dwb_sel_i = '0;
        dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        check_tohost("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Fetch of a freshly written instruction, and of untouched NOP background.
        do_data(32'h0, 32'h00500093, 1'b1, 4'hF, "w0", rd);
        do_fetch(32'h0, "f0", rd);
        check("f0_const", rd, 32'h00500093);
        do_fetch(32'h44, "f17", rd);

        // Byte-masked write over NOP background.
        do_data(32'h14, 32'hAABBCCDD, 1'b1, 4'b0101, "wmask", rd);
        do_data(32'h16, 32'h0, 1'b0, 4'hF, "rmask", rd);
        check("mask_const", rd, 32'h00BB00DD);

        // sel=0 acks but writes nothing.
        do_data(32'h18, 32'hFFFFFFFF, 1'b1, 4'h0, "wsel0", rd);
        do_data(32'h18, 32'h0, 1'b0, 4'hF, "rsel0", rd);

        // Same-edge data write and fetch of word 8: fetch sees old word.
        fork
            d_access(32'h20, 32'h00000073, 1'b1, 4'hF, rd2, ack, err, lat);
            begin
                logic [31:0] frd;
                logic fa, fe;
                int fl;
                repeat (3) @(posedge clk);
                #1;
                i_access(32'h20, frd, fa, fe, fl);
                check("same_f_ack", 32'(fa), 32'd1);
                check("same_f_lat", 32'(fl), 32'd1);
                check("same_f_old", frd, 32'h00000013);
            end
        join
        check("same_d_ack", 32'(ack), 32'd1);
        check("same_d_lat", 32'(lat), DW + 1);
        ref_wr(8, 32'h00000073, 4'hF);
        @(posedge clk); #1;
        do_fetch(32'h20, "same_next", rd);
        check("same_new", rd, 32'h00000073);

        // Out of range: err, zero data, no aliasing write onto word 0.
        do_data(32'h00008000, 32'h0, 1'b0, 4'hF, "oor_rd", rd);
        do_data(32'h00008000, 32'hDEADBEEF, 1'b1, 4'hF, "oor_wr", rd);
        do_data(32'h0, 32'h0, 1'b0, 4'hF, "oor_chk", rd);
        do_fetch(32'hFFFFFFFC, "oor_f", rd);

        // Master abandons a write in WAIT: no response, no write.
        dwb_adr_i = 32'h24; dwb_dat_i = 32'h11223344; dwb_we_i = 1'b1; dwb_sel_i = 4'hF;
        dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
        seen = 1'b0;
        repeat (2) begin @(posedge clk); #1; seen |= dwb_ack_o | dwb_err_o; end
        dwb_stb_i = 1'b0; dwb_cyc_i = 1'b0; dwb_we_i = 1'b0;
        repeat (6) begin @(posedge clk); #1; seen |= dwb_ack_o | dwb_err_o; end
        check("abort_noresp", 32'(seen), 32'd0);
        do_data(32'h24, 32'h0, 1'b0, 4'hF, "abort_rd", rd);

        // Reset during WAIT of a write: dropped, outputs quiet, word unchanged.
        dwb_adr_i = 32'h28; dwb_dat_i = 32'h12345678; dwb_we_i = 1'b1; dwb_sel_i = 4'hF;
        dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1; #1;
        check_quiet("rstwait_in");
        @(posedge clk); #1;
        dwb_stb_i = 1'b0; dwb_cyc_i = 1'b0; dwb_we_i = 1'b0;
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin @(posedge clk); #1; seen |= dwb_ack_o | dwb_err_o; end
        check("rstwait_noresp", 32'(seen), 32'd0);
        check_quiet("rstwait_after");
        do_data(32'h28, 32'h0, 1'b0, 4'hF, "rstwait_rd", rd);
        check("rstwait_const", rd, 32'h00000013);

        // Randomized sequential traffic, then concurrent traffic on disjoint words.
        for (int n = 0; n < 120; n++) begin
            logic [31:0] a;
            int unsigned k = $urandom_range(0, 9);
            if (k == 0) a = {DEPTH + $urandom_range(0, 200), 2'(0)};
            else        a = {30'($urandom_range(0, 31)), 2'($urandom)};
            if (k < 3) do_fetch(a, "rnd_f", rd);
            else       do_data(a, $urandom, 1'($urandom), 4'($urandom), "rnd_d", rd);
        end
        for (int n = 0; n < 20; n++) begin
            logic [31:0] fa, da, wd;
            logic [3:0] s;
            fa = {30'($urandom_range(0, 15)), 2'b00};
            da = {30'($urandom_range(16, 31)), 2'b00};
            wd = $urandom;
            s  = 4'($urandom);
            fork
                begin logic [31:0] r1; do_fetch(fa, "cc_f", r1); end
                begin logic [31:0] r2; do_data(da, wd, 1'b1, s, "cc_d", r2); end
            join
        end

        // tohost latch behaviour.
        do_data(TH * 4, 32'd1, 1'b1, 4'hF, "th1", rd);
`ifdef WB_MEM_TOHOST_EN
        check("th1_pass_const", 32'(tohost_pass), 32'd1);
`else
        check("th1_pass_const", 32'(tohost_pass), 32'd0);
`endif
        do_data(TH * 4, 32'd5, 1'b1, 4'hF, "th_sticky", rd);
        pulse_reset();
        do_data(TH * 4, 32'd0, 1'b1, 4'hF, "th_zero", rd);
        do_data(TH * 4, 32'd7, 1'b1, 4'hF, "th7", rd);
`ifdef WB_MEM_TOHOST_EN
        check("th7_code_const", 32'(tohost_code), 32'd3);
`else
        check("th7_code_const", 32'(tohost_code), 32'd0);
`endif
        do_data(TH * 4, 32'h0, 1'b0, 4'hF, "th_rd", rd);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
